// File: rtl/cmos_updown_counter.sv
// rtl/cmos_updown_counter.sv - modulo up/down counter with clamped load, terminal count and sticky overflow
module cmos_updown_counter #(
   parameter int WIDTH    = 4,
   parameter int MODULO   = 2 ** WIDTH,
   parameter bit SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] D,
   input  logic             clr_ov,
   output logic [WIDTH-1:0] Q,
   output logic             TC,
   output logic             OV
);

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   logic             at_top;
   logic             at_bot;
   logic [WIDTH-1:0] q_next;
   logic             ov_set;
   logic             ov_next;

   assign at_top = (Q == MAX_VAL);
   assign at_bot = (Q == '0);

   // Raised in the cycle whose edge will wrap or saturate, so consumers see it at that same edge.
   assign TC = en & ((up & at_top) | (~up & at_bot));

   always_comb begin
      q_next = Q;
      ov_set = 1'b0;
      if (load) begin
         q_next = (D > MAX_VAL) ? MAX_VAL : D;
      end else if (en) begin
         if (up) begin
            if (at_top) begin
               ov_set = 1'b1;
               q_next = SATURATE ? Q : '0;
            end else begin
               q_next = Q + ONE;
            end
         end else begin
            if (at_bot) begin
               ov_set = 1'b1;
               q_next = SATURATE ? Q : MAX_VAL;
            end else begin
               q_next = Q - ONE;
            end
         end
      end
   end

   // A set event on the same edge as clr_ov leaves the flag high.
   assign ov_next = ov_set | (OV & ~clr_ov);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         Q  <= '0;
         OV <= 1'b0;
      end else begin
         Q  <= q_next;
         OV <= ov_next;
      end
   end

endmodule

// File: tb/tb_cmos_updown_counter.sv
// tb/tb_cmos_updown_counter.sv - directed scoreboard bench for wrap and saturate counter variants
module tb_cmos_updown_counter;

   logic       clk;
   logic       rst;
   logic       en;
   logic       up;
   logic       load;
   logic [3:0] d;
   logic       clr_ov;
   logic [3:0] w_q;
   logic       w_tc;
   logic       w_ov;
   logic [3:0] s_q;
   logic       s_tc;
   logic       s_ov;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string tag;
      int    wq, wtc, wov, sq, stc, sov;
   } exp_t;

   exp_t sb[$];

   cmos_updown_counter #(.WIDTH(4), .MODULO(10), .SATURATE(1'b0)) u_wrap (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .D(d),
      .clr_ov(clr_ov), .Q(w_q), .TC(w_tc), .OV(w_ov)
   );

   cmos_updown_counter #(.WIDTH(4), .MODULO(10), .SATURATE(1'b1)) u_sat (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .D(d),
      .clr_ov(clr_ov), .Q(s_q), .TC(s_tc), .OV(s_ov)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int e);
      checks++;
      assert (obs === e) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, e);
      end
   endtask

   task automatic push(input string tag, input int wq, input int wtc, input int wov,
                       input int sq, input int stc, input int sov);
      exp_t e;
      e.tag = tag;
      e.wq = wq; e.wtc = wtc; e.wov = wov;
      e.sq = sq; e.stc = stc; e.sov = sov;
      sb.push_back(e);
   endtask

   task automatic cmp();
      exp_t e;
      if (sb.size() == 0) begin
         chk("scoreboard_underflow", 0, 1);
      end else begin
         e = sb.pop_front();
         chk({e.tag, "_wrap_q"},  int'(w_q),  e.wq);
         chk({e.tag, "_wrap_tc"}, int'(w_tc), e.wtc);
         chk({e.tag, "_wrap_ov"}, int'(w_ov), e.wov);
         chk({e.tag, "_sat_q"},   int'(s_q),  e.sq);
         chk({e.tag, "_sat_tc"},  int'(s_tc), e.stc);
         chk({e.tag, "_sat_ov"},  int'(s_ov), e.sov);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; d = 4'd0; clr_ov = 1'b0;
      push("reset", 0, 0, 0, 0, 0, 0);
      tick();
      cmp();

      // Load 7, then async reset between edges.
      rst = 1'b0; load = 1'b1; d = 4'd7;
      push("load7", 7, 0, 0, 7, 0, 0);
      tick();
      cmp();
      load = 1'b0;
      #2 rst = 1'b1;
      push("async_rst", 0, 0, 0, 0, 0, 0);
      #1 cmp();
      #1 rst = 1'b0; en = 1'b1; up = 1'b1;
      push("post_rst_1", 1, 0, 0, 1, 0, 0);
      push("post_rst_2", 2, 0, 0, 2, 0, 0);
      push("post_rst_3", 3, 0, 0, 3, 0, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         cmp();
      end

      // Count up through the top of range.
      en = 1'b0; load = 1'b1; d = 4'd8;
      tick();
      load = 1'b0; en = 1'b1; up = 1'b1;
      push("up_q8", 8, 0, 0, 8, 0, 0);
      #1 cmp();
      push("up_q9", 9, 1, 0, 9, 1, 0);
      push("up_wrap", 0, 0, 1, 9, 1, 1);
      push("up_after1", 1, 0, 1, 9, 1, 1);
      push("up_after2", 2, 0, 1, 9, 1, 1);
      for (int i = 0; i < 4; i++) begin
         tick();
         cmp();
      end

      en = 1'b0; clr_ov = 1'b1;
      push("clr_ov_alone", 2, 0, 0, 9, 0, 0);
      tick();
      cmp();
      clr_ov = 1'b0;

      // Count down through zero.
      load = 1'b1; d = 4'd1;
      tick();
      load = 1'b0; en = 1'b1; up = 1'b0;
      push("dn_q1", 1, 0, 0, 1, 0, 0);
      #1 cmp();
      push("dn_q0", 0, 1, 0, 0, 1, 0);
      push("dn_wrap", 9, 0, 1, 0, 1, 1);
      push("dn_after", 8, 0, 1, 0, 1, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         cmp();
      end

      en = 1'b0; clr_ov = 1'b1;
      push("clr_ov_2", 8, 0, 0, 0, 0, 0);
      tick();
      cmp();
      clr_ov = 1'b0;

      // Clamped load beats counting and never sets OV, even at the top.
      load = 1'b1; d = 4'd13; en = 1'b1; up = 1'b1;
      push("load_clamp13", 9, 1, 0, 9, 1, 0);
      tick();
      cmp();
      d = 4'd15;
      push("load_clamp15_at_top", 9, 1, 0, 9, 1, 0);
      tick();
      cmp();

      // Reset wins over a load on the same edge.
      d = 4'd4; rst = 1'b1;
      push("rst_over_load", 0, 0, 0, 0, 0, 0);
      tick();
      cmp();
      rst = 1'b0; load = 1'b0; en = 1'b0;

      // Set and clear on the same edge: set wins.
      load = 1'b1; d = 4'd9;
      tick();
      load = 1'b0; en = 1'b1; up = 1'b1; clr_ov = 1'b1;
      push("setclr_pre", 9, 1, 0, 9, 1, 0);
      #1 cmp();
      push("setclr_edge", 0, 0, 1, 9, 1, 1);
      tick();
      cmp();
      clr_ov = 1'b0; en = 1'b0;
      push("ov_sticky_hold", 0, 0, 1, 9, 0, 1);
      tick();
      cmp();

      chk("scoreboard_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
